// File: rtl/fphub_div_pkg.sv
// Shared operand classes and special-magnitude constants for the FPHUB divider front-end.
package fphub_div_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_ONE    = 2'd2,
    CLS_INF    = 2'd3
  } cls_e;

  // Magnitudes are built at full width and sliced to E+M bits by the user.
  localparam int unsigned MAG_MAX = 64;

  function automatic logic [MAG_MAX-1:0] mag_inf(input int unsigned e, input int unsigned m);
    logic [MAG_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAG_MAX; i++) begin
      if (i < e + m) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAG_MAX-1:0] mag_zero(input int unsigned e, input int unsigned m);
    logic [MAG_MAX-1:0] r;
    r = '0;
    if (e + m > MAG_MAX) r = '1;
    return '0 & r;
  endfunction

  // exp = 1 followed by E-1 zeros, mantissa zero: only the exponent MSB is set.
  function automatic logic [MAG_MAX-1:0] mag_one(input int unsigned e, input int unsigned m);
    logic [MAG_MAX-1:0] r;
    r = '0;
    r[e + m - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fphub_operand_classifier.sv
// Maps an operand magnitude {exp, mant} to its class; sign does not take part.
module fphub_operand_classifier
  import fphub_div_pkg::*;
#(
  parameter int unsigned E = 8,
  parameter int unsigned M = 23
) (
  input  logic [E+M-1:0] mag,
  output cls_e           cls
);

  localparam logic [MAG_MAX-1:0] INF_W  = mag_inf(E, M);
  localparam logic [MAG_MAX-1:0] ZERO_W = mag_zero(E, M);
  localparam logic [MAG_MAX-1:0] ONE_W  = mag_one(E, M);
  localparam logic [E+M-1:0]     INF    = INF_W[E+M-1:0];
  localparam logic [E+M-1:0]     ZERO   = ZERO_W[E+M-1:0];
  localparam logic [E+M-1:0]     ONE    = ONE_W[E+M-1:0];

  always_comb begin
    cls = CLS_NORMAL;
    if (mag == INF)       cls = CLS_INF;
    else if (mag == ZERO) cls = CLS_ZERO;
    else if (mag == ONE)  cls = CLS_ONE;
  end

endmodule

// File: rtl/fphub_div_special_pipe.sv
// Two-stage elastic special-case resolver in front of the FPHUB divider core,
// with tag pass-through and sticky divide-by-zero / invalid flags.
module fphub_div_special_pipe
  import fphub_div_pkg::*;
#(
  parameter int unsigned M     = 23,
  parameter int unsigned E     = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     x,
  input  logic [E+M:0]     y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_special,
  output logic [E+M:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_dz,
  output logic             flag_nv,
  input  logic             flags_clr
);

  localparam int unsigned W = E + M + 1;
  localparam logic [MAG_MAX-1:0] INF_W  = mag_inf(E, M);
  localparam logic [MAG_MAX-1:0] ZERO_W = mag_zero(E, M);
  localparam logic [MAG_MAX-1:0] ONE_W  = mag_one(E, M);
  localparam logic [E+M-1:0]     INF    = INF_W[E+M-1:0];
  localparam logic [E+M-1:0]     ZERO   = ZERO_W[E+M-1:0];
  localparam logic [E+M-1:0]     ONE    = ONE_W[E+M-1:0];

  cls_e             cx, cy;
  logic             s1_valid, s2_valid;
  logic [W-1:0]     s1_x, s1_y;
  logic [TAG_W-1:0] s1_tag;
  cls_e             s1_cx, s1_cy;
  logic             s2_dz, s2_nv;
  logic             s1_adv, s2_adv, out_hs;

  logic             sgn;
  logic             r_special, r_dz, r_nv;
  logic [W-1:0]     r_result;

  fphub_operand_classifier #(.E(E), .M(M)) u_cls_x (.mag(x[E+M-1:0]), .cls(cx));
  fphub_operand_classifier #(.E(E), .M(M)) u_cls_y (.mag(y[E+M-1:0]), .cls(cy));

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_hs    = s2_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_tag   <= '0;
      s1_cx    <= CLS_NORMAL;
      s1_cy    <= CLS_NORMAL;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= x;
        s1_y   <= y;
        s1_tag <= in_tag;
        s1_cx  <= cx;
        s1_cy  <= cy;
      end
    end
  end

  always_comb begin
    sgn       = s1_x[W-1] ^ s1_y[W-1];
    r_special = 1'b1;
    r_result  = '0;
    r_dz      = 1'b0;
    r_nv      = 1'b0;
    if (s1_cx == CLS_INF && s1_cy == CLS_INF) begin
      r_result = {sgn, INF};
      r_nv     = 1'b1;
    end else if (s1_cx == CLS_ZERO && s1_cy == CLS_ZERO) begin
      r_result = {sgn, INF};
      r_nv     = 1'b1;
    end else if (s1_cx == CLS_INF) begin
      r_result = {sgn, INF};
    end else if (s1_cy == CLS_ZERO) begin
      r_result = {sgn, INF};
      r_dz     = 1'b1;
    end else if (s1_cy == CLS_INF) begin
      r_result = {sgn, ZERO};
    end else if (s1_cx == CLS_ZERO) begin
      r_result = {sgn, ZERO};
    end else if (s1_cy == CLS_ONE) begin
      r_result = {sgn, s1_x[E+M-1:0]};
    end else if (s1_x[E+M-1:0] == s1_y[E+M-1:0]) begin
      r_result = {sgn, ONE};
    end else begin
      r_special = 1'b0;
    end
  end

  // Stage-2 payload only loads with a real op, so a held result never changes under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_special <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      s2_dz       <= 1'b0;
      s2_nv       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_special <= r_special;
        out_result  <= r_result;
        out_tag     <= s1_tag;
        s2_dz       <= r_dz;
        s2_nv       <= r_nv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_dz <= 1'b0;
      flag_nv <= 1'b0;
    end else begin
      if (out_hs && s2_dz)  flag_dz <= 1'b1;
      else if (flags_clr)   flag_dz <= 1'b0;
      if (out_hs && s2_nv)  flag_nv <= 1'b1;
      else if (flags_clr)   flag_nv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fphub_div_special_pipe.sv
// Self-checking bench: directed table, random stream against a reference model,
// stall/ordering sequence and mid-flight reset.
module tb_fphub_div_special_pipe;

  localparam int unsigned E = 8;
  localparam int unsigned M = 23;
  localparam int unsigned TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_special;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        flag_dz, flag_nv;
  logic        flags_clr = 1'b0;

  always #5 clk = ~clk;

  fphub_div_special_pipe #(.M(M), .E(E), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_special(out_special), .out_result(out_result), .out_tag(out_tag),
    .flag_dz(flag_dz), .flag_nv(flag_nv), .flags_clr(flags_clr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        special;
    logic [31:0] result;
    logic [3:0]  tag;
    logic        dz;
    logic        nv;
  } res_t;

  // Reference: classify by comparing the 31-bit magnitude against literal encodings.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    res_t r;
    logic [30:0] ma, mb;
    logic s;
    ma = a[30:0];
    mb = b[30:0];
    s = a[31] ^ b[31];
    r.special = 1'b1; r.result = '0; r.tag = t; r.dz = 1'b0; r.nv = 1'b0;
    if (ma == 31'h7FFFFFFF && mb == 31'h7FFFFFFF) begin r.result = {s, 31'h7FFFFFFF}; r.nv = 1'b1; end
    else if (ma == 0 && mb == 0)                   begin r.result = {s, 31'h7FFFFFFF}; r.nv = 1'b1; end
    else if (ma == 31'h7FFFFFFF)                   r.result = {s, 31'h7FFFFFFF};
    else if (mb == 0)                              begin r.result = {s, 31'h7FFFFFFF}; r.dz = 1'b1; end
    else if (mb == 31'h7FFFFFFF)                   r.result = {s, 31'h0};
    else if (ma == 0)                              r.result = {s, 31'h0};
    else if (mb == 31'h40000000)                   r.result = {s, ma};
    else if (ma == mb)                             r.result = {s, 31'h40000000};
    else                                           r.special = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:0] = '0;
      1: v[30:0] = '1;
      2: v[30:0] = 31'h40000000;
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: scoreboard, flag model and stall-stability check, sampled on negedge.
  res_t        q[$];
  res_t        e;
  logic        mon_en = 1'b0;
  logic        m_dz = 1'b0, m_nv = 1'b0;
  logic        sd, sn;
  logic        hold_v = 1'b0;
  logic [36:0] hold = '0;
  int          pops = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_dz = 1'b0; m_nv = 1'b0; hold_v = 1'b0;
    end else if (mon_en) begin
      check("flag_dz", flag_dz, m_dz);
      check("flag_nv", flag_nv, m_nv);
      if (hold_v) check("stall_hold", {out_valid, out_special, out_result, out_tag}, {1'b1, hold});
      sd = 1'b0; sn = 1'b0;
      if (out_valid && out_ready) begin
        pops++;
        if (q.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          e = q.pop_front();
          check("out", {out_special, out_result, out_tag}, {e.special, e.result, e.tag});
          sd = e.dz; sn = e.nv;
        end
      end
      m_dz = sd ? 1'b1 : (flags_clr ? 1'b0 : m_dz);
      m_nv = sn ? 1'b1 : (flags_clr ? 1'b0 : m_nv);
      hold_v = out_valid && !out_ready;
      hold = {out_special, out_result, out_tag};
      if (in_valid && in_ready) q.push_back(model(x, y, in_tag));
    end
  end

  typedef struct {
    logic [31:0] x, y;
    logic [3:0]  tag;
    logic        sp;
    logic [31:0] res;
    logic        dz, nv;
  } vec_t;

  vec_t tbl[14];

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; x = v.x; y = v.y; in_tag = v.tag; out_ready = 1'b1; flags_clr = 1'b0;
    check("tbl_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("tbl_lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("tbl_lat2_valid", out_valid, 1);
    check("tbl_result", {out_special, out_result, out_tag}, {v.sp, v.res, v.tag});
    @(posedge clk); #1;
    check("tbl_flags", {flag_dz, flag_nv}, {v.dz, v.nv});
    check("tbl_drained", out_valid, 0);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("tbl_flags_clr", {flag_dz, flag_nv}, 2'b00);
  endtask

  logic [31:0] xs[8], ys[8];
  int sent, pops0, vcount;
  logic acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h40800000, 32'hC0000000, 4'd3,  1'b1, 32'hC0800000, 1'b0, 1'b0};
    tbl[1]  = '{32'h3F000001, 32'h00000000, 4'd1,  1'b1, 32'h7FFFFFFF, 1'b1, 1'b0};
    tbl[2]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 4'd2,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[3]  = '{32'h80000000, 32'h00000000, 4'd4,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[4]  = '{32'h41234567, 32'h41234567, 4'd5,  1'b1, 32'h40000000, 1'b0, 1'b0};
    tbl[5]  = '{32'h41000000, 32'h40800000, 4'd6,  1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[6]  = '{32'h7FFFFFFF, 32'h3F800000, 4'd7,  1'b1, 32'h7FFFFFFF, 1'b0, 1'b0};
    tbl[7]  = '{32'h3F800000, 32'hFFFFFFFF, 4'd8,  1'b1, 32'h80000000, 1'b0, 1'b0};
    tbl[8]  = '{32'h80000000, 32'h3F800000, 4'd9,  1'b1, 32'h80000000, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000000, 32'hC0000000, 4'd10, 1'b1, 32'h80000000, 1'b0, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 32'h00000000, 4'd11, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0};
    tbl[11] = '{32'h40000000, 32'h40000000, 4'd12, 1'b1, 32'h40000000, 1'b0, 1'b0};
    tbl[12] = '{32'h41234567, 32'hC1234567, 4'd13, 1'b1, 32'hC0000000, 1'b0, 1'b0};
    tbl[13] = '{32'h12345678, 32'h12345679, 4'd15, 1'b0, 32'h00000000, 1'b0, 1'b0};

    // Reset state
    #22;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_special, out_result, out_tag}, 37'h0);
    check("rst_flags", {flag_dz, flag_nv}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Random stream with random backpressure and clears
    acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x = rnd_op();
        y = rnd_op();
        if ($urandom_range(0, 5) == 0) y[30:0] = x[30:0];
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flags_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin @(posedge clk); #1; end
    check("rand_drain", q.size(), 0);

    // Back-to-back tags 0..7 with output stalled for 5 cycles
    for (int i = 0; i < 8; i++) begin
      xs[i] = rnd_op();
      ys[i] = rnd_op();
    end
    pops0 = pops;
    sent = 0;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      out_ready = (c >= 5);
      in_valid = 1'b1; x = xs[sent]; y = ys[sent]; in_tag = sent[3:0];
      @(negedge clk);
      if (c == 4) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", sent, 2);
        check("stall_out_tag", out_tag, 0);
      end
      if (in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_sent", sent, 8);
    for (int c = 0; c < 20 && q.size() != 0; c++) begin @(posedge clk); #1; end
    check("stall_drain", q.size(), 0);
    check("stall_pops", pops - pops0, 8);

    // Set a flag, fill both stages, then reset mid-flight
    @(posedge clk); #1;
    in_valid = 1'b1; x = 32'h3F800000; y = 32'h00000000; in_tag = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_flag_dz", flag_dz, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; x = 32'h40800000; y = 32'h40000000; in_tag = 4'd1;
    @(posedge clk); #1;
    x = 32'h41000000; y = 32'h40800000; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_flags", {flag_dz, flag_nv}, 2'b00);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_outputs", {out_special, out_result, out_tag}, 37'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("no_stale_after_rst", vcount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fphub_div_special_pipe.md
Name: fphub_div_special_pipe

Overview:
- Pipelined, elastic front-end for the FPHUB divider.
- Classifies both operands, resolves the full special-case priority, and returns a registered special result plus a bypass flag, so the iterative divider core only handles ordinary operands.
- Successor to the combinational special-result logic. Adds:
  - a valid/ready handshake with 2-cycle latency;
  - an opaque tag pass-through;
  - an equal-operand (result = 1) case;
  - sticky divide-by-zero and invalid flags.

Parameters:
- M, 23, mantissa width.
- E, 8, exponent width.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- x  in  E+M+1  dividend, HUB encoding {sign, exp, mant}.
- y  in  E+M+1  divisor, same encoding.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_special  out  1  1 = out_result is final and the core is bypassed; 0 = core must compute.
- out_result  out  E+M+1  special result; all-zero when out_special=0.
- out_tag  out  TAG_W  tag of this result.
- flag_dz  out  1  sticky divide-by-zero flag.
- flag_nv  out  1  sticky invalid-operation flag.
- flags_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Encodings, where mag = {exp, mant}:
  - INF: mag all ones.
  - ZERO: mag all zeros.
  - ONE: exp = 1 followed by E-1 zeros, mant zero.
  - NORMAL: anything else.
  - The sign bit is ignored for classification.
- Result sign is s = x[E+M] ^ y[E+M] in every special case, including invalid results.
- Priority: first match wins. Conditions are evaluated on the stage-1 registered classes.
  1. X INF and Y INF -> {s, INF}, nv.
  2. X ZERO and Y ZERO -> {s, INF}, nv.
  3. X INF -> {s, INF}.
  4. Y ZERO -> {s, INF}, dz.
  5. Y INF -> {s, ZERO}.
  6. X ZERO -> {s, ZERO}.
  7. Y ONE -> {s, mag(X)}.
  8. mag(X) == mag(Y) -> {s, ONE}.
  9. Otherwise out_special=0, out_result=0.
- Pipeline:
  - Stage 1 registers the operands, tag, and the 2-bit class of each operand.
  - Stage 2 registers the resolved result, special bit, tag, and per-op dz/nv bits.
  - Latency is exactly 2 cycles from the input handshake to out_valid when no stall occurs.
  - Throughput is 1 operation per cycle.
- Handshake:
  - Each stage has a valid bit.
  - Stage 2 advances when !s2_valid or out_ready.
  - Stage 1 advances when !s1_valid or stage 2 advances.
  - in_ready = !s1_valid || s2_adv. It is combinational, with no dependence on in_valid.
  - A stalled stage holds its data unchanged.
  - out_valid = s2_valid.
  - Once out_valid is asserted, out_result, out_special and out_tag stay stable until out_ready.
- Sticky flags:
  - Each flag is set on the output handshake (out_valid && out_ready) when that op's dz/nv bit is 1.
  - flags_clr clears both flags.
  - If clr and set occur in the same cycle, set wins.
- Reset (asynchronous):
  - s1_valid, s2_valid, flag_dz, flag_nv, out_special, out_result and out_tag all go to 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards all in-flight ops; no partial output appears.
- No combinational path from x/y to any output.

Decomposition:
- Package fphub_div_pkg:
  - class enum {CLS_NORMAL, CLS_ZERO, CLS_ONE, CLS_INF};
  - functions returning the INF/ZERO/ONE magnitudes parametrised by E and M.
- Sub-module fphub_operand_classifier (combinational, parameters E and M): maps an operand to its class. Instantiated twice, once for x and once for y.

Test Plan (E=8, M=23, TAG_W=4):
- X=0x40800000, Y=0xC0000000 (-1), tag=3 -> two cycles later: out_special=1, out_result=0xC0800000, out_tag=3, no flags.
- X=0x3F000001, Y=0x00000000 -> out_result=0x7FFFFFFF, special=1, flag_dz=1 after handshake. Then pulse flags_clr -> flag_dz=0.
- X=0x7FFFFFFF, Y=0xFFFFFFFF -> out_result=0xFFFFFFFF, flag_nv=1. X=0x80000000, Y=0x00000000 -> 0xFFFFFFFF, nv.
- X=Y=0x41234567 -> out_result=0x40000000, special=1. X=0x41000000, Y=0x40800000 -> special=0, result=0.
- Back-to-back ops with tags 0..7 and out_ready held low for 5 cycles:
  - in_ready drops once both stages are full;
  - outputs stay stable during the stall;
  - all 8 results then emerge in order with no loss or duplication.
- Assert rst while 2 ops are in flight -> out_valid=0 immediately, flags=0, in_ready=1, no stale result appears after release.
